// File: rtl/tube_pkg.sv
// Shared types and constants for the drift-tube readout sequencer.
package tube_pkg;

    localparam int unsigned TUBE_W = 8;
    localparam int unsigned FIFO_W = 16;
    localparam int unsigned IDX_W  = 8;
    localparam logic [7:0]  HEADER_TAG = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        SETTLE,
        HEADER,
        READ,
        CLEAR
    } state_t;

endpackage

// File: rtl/tube_readout_ctrl_if.sv
// Trigger, tube-counter and FIFO signals of the readout sequencer.
interface tube_readout_ctrl_if
    import tube_pkg::*;
#(
    parameter int unsigned NUM_TUBES = 8
);

    logic                          scinTrig;
    logic [TUBE_W*NUM_TUBES-1:0]   tubeData;
    logic                          fifoFull;
    logic                          gateEnable;
    logic                          tubeClr;
    logic                          fifoWrEn;
    logic [FIFO_W-1:0]             fifoDin;
    logic                          busy;
    logic [7:0]                    missedTrig;

    // master = sequencer side, slave = trigger/counter/FIFO environment
    modport master (
        input  scinTrig, tubeData, fifoFull,
        output gateEnable, tubeClr, fifoWrEn, fifoDin, busy, missedTrig
    );

    modport slave (
        output scinTrig, tubeData, fifoFull,
        input  gateEnable, tubeClr, fifoWrEn, fifoDin, busy, missedTrig
    );

endinterface

// File: rtl/trig_edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus a registered
// single-cycle rising-edge pulse.
module trig_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            prev <= sync[1];
            rise <= sync[1] & ~prev;
        end
    end

endmodule

// File: rtl/tube_readout_ctrl.sv
// Event sequencer: gate all tube counters on a trigger, let them settle,
// stream header plus every tube count into the FIFO, then clear and re-arm.
module tube_readout_ctrl
    import tube_pkg::*;
#(
    parameter int unsigned NUM_TUBES     = 8,
    parameter int unsigned GATE_CYCLES   = 200,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                clr,
    tube_readout_ctrl_if.master bus
);

    localparam int unsigned CNT_MAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TUBES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [7:0]         event_num, event_nxt;
    logic [7:0]         missed, missed_nxt;
    logic               trig_rise;
    logic               wr_en;
    logic [TUBE_W-1:0]  sel;
    logic [FIFO_W-1:0]  din;

    trig_edge_sync u_trig_sync (
        .clk  (clk),
        .rst  (clr),
        .din  (bus.scinTrig),
        .rise (trig_rise)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            event_num <= '0;
            missed    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            event_num <= event_nxt;
            missed    <= missed_nxt;
        end
    end

    // Next-state logic; one down-counter times both GATE and SETTLE
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        event_nxt  = event_num;
        missed_nxt = missed;
        wr_en      = ((state == HEADER) || (state == READ)) && !bus.fifoFull;

        if (trig_rise && (state != IDLE) && (missed != 8'hFF))
            missed_nxt = missed + 8'd1;

        case (state)
            IDLE: begin
                if (trig_rise) begin
                    state_nxt = GATE;
                    cnt_nxt   = CNT_W'(GATE_CYCLES - 1);
                end
            end
            GATE: begin
                if (cnt == '0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_nxt = HEADER;
                else           cnt_nxt   = cnt - 1'b1;
            end
            HEADER: begin
                if (wr_en) begin
                    state_nxt = READ;
                    idx_nxt   = '0;
                end
            end
            READ: begin
                if (wr_en) begin
                    if (idx == LAST_IDX) state_nxt = CLEAR;
                    else                 idx_nxt   = idx + 1'b1;
                end
            end
            CLEAR: begin
                state_nxt = IDLE;
                event_nxt = event_num + 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Readout mux: selected tube count and the word presented to the FIFO
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_TUBES; i++) begin
            if (idx == IDX_W'(i)) sel = bus.tubeData[i*TUBE_W +: TUBE_W];
        end
        case (state)
            HEADER:  din = {HEADER_TAG, event_num};
            READ:    din = {idx, sel};
            default: din = '0;
        endcase
    end

    assign bus.gateEnable = (state == GATE);
    assign bus.tubeClr    = clr | (state == CLEAR);
    assign bus.fifoWrEn   = wr_en;
    assign bus.fifoDin    = din;
    assign bus.busy       = (state != IDLE);
    assign bus.missedTrig = missed;

endmodule
